// File: rtl/if_fetch_buffer_pkg.sv
// Shared definitions for the instruction-fetch buffer: word size, FSM states,
// prefetch entry layout and target alignment.
package if_fetch_buffer_pkg;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_buffer_fifo.sv
// Synchronous prefetch FIFO: DEPTH entries, push/pop in the same cycle,
// single-cycle flush. Head data is read combinationally from storage.
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_C);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign data_out = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: sequential word fetch with credit-limited prefetch,
// in-order response buffering and redirect with drop of stale responses.
module if_fetch_buffer
  import if_fetch_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redirect_imm
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_next;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  head;
  logic [31:0]   target;
  logic          req_fire;
  logic          resp_in_run;
  logic          resp_take;
  logic          pop;

  // Handshakes: a request transfers on the cycle imem_req_valid & imem_req_ready
  // are both high; the ID transfer happens on id_valid & id_ready; a response is
  // a one-cycle imem_resp_valid pulse with no backpressure.
  assign target         = align_word(redirect_pc + redirect_imm);
  assign imem_req_valid = ~reset & (state == RUN) & ~redirect
                        & (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign resp_in_run    = imem_resp_valid & (outstanding != '0);
  assign resp_take      = (state == RUN) & ~redirect & resp_in_run;
  assign drop_next      = outstanding - CW'(resp_in_run);

  assign id_valid = ~fifo_empty;
  assign id_pc    = head.pc;
  assign id_instr = head.instr;
  assign pop      = id_valid & id_ready;

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (resp_take),
    .pop      (pop),
    .flush    (redirect),
    .data_in  ({resp_pc, imem_resp_data}),
    .data_out (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            // Anything still in flight belongs to the old path and must be dropped.
            fetch_pc    <= target;
            resp_pc     <= target;
            outstanding <= '0;
            drop_cnt    <= drop_next;
            state       <= (drop_next != '0) ? FLUSH : RUN;
          end else begin
            if (req_fire)  fetch_pc <= fetch_pc + INSTR_BYTES;
            if (resp_take) resp_pc  <= resp_pc + INSTR_BYTES;
            case ({req_fire, resp_take})
              2'b10:   outstanding <= outstanding + 1'b1;
              2'b01:   outstanding <= outstanding - 1'b1;
              default: ;
            endcase
          end
        end
        FLUSH: begin
          if (redirect) begin
            fetch_pc <= target;
            resp_pc  <= target;
          end
          if (imem_resp_valid && drop_cnt != '0) begin
            drop_cnt <= drop_cnt - 1'b1;
            if (drop_cnt == CW'(1)) state <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: in-order memory model with random latency and a
// program-order reference for request addresses and the ID stream.
module tb_if_fetch_buffer;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_imm;

  always #5 clk = ~clk;

  if_fetch_buffer #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_ready        (id_ready),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .redirect_imm    (redirect_imm)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int req_ready_pct = 100;
  int id_ready_pct  = 100;
  int lat_min       = 1;
  int lat_max       = 1;

  // memory model: accepted addresses and the cycle each response is due
  logic [31:0] mem_q[$];
  int          due_q[$];

  // reference: next address to be requested and next PC ID must see
  logic [31:0] exp_req_addr;
  logic [31:0] exp_id_pc;

  logic        obs_req_valid, obs_req_fire, obs_id_valid, obs_id_fire;
  logic [31:0] obs_req_addr, obs_id_pc, obs_id_instr;
  logic [31:0] want_req_addr, want_id_pc, want_id_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
  endfunction

  task automatic step(input logic rdr, input logic [31:0] rpc, input logic [31:0] rimm);
    int d;
    @(negedge clk);
    imem_req_ready  = (int'($urandom_range(99)) < req_ready_pct);
    id_ready        = (int'($urandom_range(99)) < id_ready_pct);
    redirect        = rdr;
    redirect_pc     = rpc;
    redirect_imm    = rimm;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (mem_q.size() > 0 && due_q[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q.pop_front());
      void'(due_q.pop_front());
    end
    #1;
    obs_req_valid = imem_req_valid;
    obs_req_addr  = imem_req_addr;
    obs_req_fire  = imem_req_valid & imem_req_ready;
    obs_id_valid  = id_valid;
    obs_id_pc     = id_pc;
    obs_id_instr  = id_instr;
    obs_id_fire   = id_valid & id_ready;
    want_req_addr = exp_req_addr;
    want_id_pc    = exp_id_pc;
    want_id_instr = mem_word(exp_id_pc);
    if (obs_req_fire) begin
      mem_q.push_back(obs_req_addr);
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (due_q.size() > 0 && d <= due_q[$]) d = due_q[$] + 1;
      due_q.push_back(d);
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (obs_id_fire) exp_id_pc = exp_id_pc + 32'd4;
    if (rdr) begin
      exp_req_addr = (rpc + rimm) & ~32'h3;
      exp_id_pc    = exp_req_addr;
    end
    cyc++;
  endtask

  task automatic drain();
    req_ready_pct = 0;
    id_ready_pct  = 100;
    repeat (14) step(1'b0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; redirect_imm = '0;
    repeat (3) @(negedge clk);
    #1;
    checks += 5;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    if (imem_req_addr !== RESET_PC) begin errors++; $display("FAIL reset_req_addr: got %h want %h", imem_req_addr, RESET_PC); end
    if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
    if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_id_instr: got %h want 0", id_instr); end
    if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
    @(negedge clk);
    reset = 1'b0;
    exp_req_addr = RESET_PC;
    exp_id_pc    = RESET_PC;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++; $display("FAIL post_reset_req: got valid %b addr %h want 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] first_addrs[3];
    logic [31:0] ref_addrs[3];
    int n_req = 0, n_id = 0, first_req = -1, first_id = -1;
    ref_addrs[0] = 32'hFFFF_FFF8; ref_addrs[1] = 32'hFFFF_FFFC; ref_addrs[2] = 32'h0000_0000;
    req_ready_pct = 100; id_ready_pct = 100; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, '0, '0);
      if (obs_req_fire) begin
        checks++;
        if (obs_req_addr !== want_req_addr) begin errors++; $display("FAIL stream_req_addr: got %h want %h", obs_req_addr, want_req_addr); end
        if (n_req < 3) first_addrs[n_req] = obs_req_addr;
        if (first_req < 0) first_req = cyc;
        n_req++;
      end
      if (obs_id_fire) begin
        checks++;
        if (obs_id_pc !== want_id_pc || obs_id_instr !== want_id_instr) begin
          errors++; $display("FAIL stream_id: got pc %h instr %h want pc %h instr %h", obs_id_pc, obs_id_instr, want_id_pc, want_id_instr);
        end
        if (first_id < 0) first_id = cyc;
        n_id++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (first_addrs[k] !== ref_addrs[k]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", k, first_addrs[k], ref_addrs[k]); end
    end
    checks++;
    if (first_id - first_req != 2) begin errors++; $display("FAIL first_latency: got %0d want 2", first_id - first_req); end
    checks++;
    if (n_id < 6) begin errors++; $display("FAIL stream_throughput: got %0d want >=6", n_id); end
  endtask

  task automatic test_backpressure();
    int accepts = 0, n_id = 0;
    lat_min = 1; lat_max = 2;
    drain();
    req_ready_pct = 100; id_ready_pct = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, '0);
      if (obs_req_fire) begin
        accepts++;
        checks++;
        if (obs_req_addr !== want_req_addr) begin errors++; $display("FAIL stall_req_addr: got %h want %h", obs_req_addr, want_req_addr); end
      end
    end
    checks += 3;
    if (accepts != DEPTH) begin errors++; $display("FAIL stall_accepts: got %0d want %0d", accepts, DEPTH); end
    if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b want 0", obs_req_valid); end
    if (obs_id_valid !== 1'b1 || obs_id_pc !== want_id_pc) begin
      errors++; $display("FAIL stall_head: got valid %b pc %h want 1 %h", obs_id_valid, obs_id_pc, want_id_pc);
    end
    req_ready_pct = 60; id_ready_pct = 100; lat_max = 3;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, '0);
      if (obs_req_fire) begin
        checks++;
        if (obs_req_addr !== want_req_addr) begin errors++; $display("FAIL resume_req_addr: got %h want %h", obs_req_addr, want_req_addr); end
      end
      if (obs_id_fire) begin
        checks++; n_id++;
        if (obs_id_pc !== want_id_pc || obs_id_instr !== want_id_instr) begin
          errors++; $display("FAIL resume_id: got pc %h instr %h want pc %h instr %h", obs_id_pc, obs_id_instr, want_id_pc, want_id_instr);
        end
      end
    end
    checks++;
    if (n_id < DEPTH) begin errors++; $display("FAIL resume_count: got %0d want >=%0d", n_id, DEPTH); end
  endtask

  task automatic test_redirect_inflight();
    int accepts = 0, rd_cyc, first_req = -1;
    logic [31:0] first_addr = '0, first_pc = '0;
    logic got_id = 1'b0;
    lat_min = 3; lat_max = 3;
    drain();
    req_ready_pct = 100; id_ready_pct = 100;
    repeat (2) begin
      step(1'b0, '0, '0);
      if (obs_req_fire) accepts++;
    end
    checks++;
    if (accepts != 2) begin errors++; $display("FAIL inflight_accepts: got %0d want 2", accepts); end
    step(1'b1, 32'h0000_0008, 32'h0000_0020);
    rd_cyc = cyc;
    checks++;
    if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL redirect_suppress: got %b want 0", obs_req_valid); end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, '0, '0);
      if (obs_req_fire) begin
        if (first_req < 0) begin first_req = cyc; first_addr = obs_req_addr; end
        checks++;
        if (obs_req_addr !== want_req_addr) begin errors++; $display("FAIL inflight_req_addr: got %h want %h", obs_req_addr, want_req_addr); end
      end
      if (obs_id_fire) begin
        if (!got_id) begin got_id = 1'b1; first_pc = obs_id_pc; end
        checks++;
        if (obs_id_pc !== want_id_pc || obs_id_instr !== want_id_instr) begin
          errors++; $display("FAIL inflight_id: got pc %h instr %h want pc %h instr %h", obs_id_pc, obs_id_instr, want_id_pc, want_id_instr);
        end
      end
    end
    checks += 3;
    if (first_addr !== 32'h28) begin errors++; $display("FAIL redirect_first_addr: got %h want 00000028", first_addr); end
    if (first_pc !== 32'h28) begin errors++; $display("FAIL redirect_first_pc: got %h want 00000028", first_pc); end
    if (first_req - rd_cyc != 3) begin errors++; $display("FAIL flush_wait: got %0d want 3", first_req - rd_cyc); end
  endtask

  task automatic test_redirect_collide();
    logic [31:0] rpc, rimm, tgt;
    int accepts = 0;
    lat_min = 1; lat_max = 1;
    drain();
    req_ready_pct = 100; id_ready_pct = 0;
    repeat (2) begin
      step(1'b0, '0, '0);
      if (obs_req_fire) accepts++;
    end
    checks++;
    if (accepts != 2) begin errors++; $display("FAIL collide_setup: got %0d want 2", accepts); end
    rpc  = $urandom & ~32'h3;
    rimm = $urandom;
    tgt  = (rpc + rimm) & ~32'h3;
    id_ready_pct = 100;
    step(1'b1, rpc, rimm);
    checks += 2;
    if (obs_id_fire !== 1'b1 || obs_id_pc !== want_id_pc || obs_id_instr !== want_id_instr) begin
      errors++; $display("FAIL collide_pop: got fire %b pc %h want 1 %h", obs_id_fire, obs_id_pc, want_id_pc);
    end
    if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL collide_req: got %b want 0", obs_req_valid); end
    req_ready_pct = 0;
    step(1'b0, '0, '0);
    checks += 2;
    if (obs_id_valid !== 1'b0) begin errors++; $display("FAIL collide_empty: got %b want 0", obs_id_valid); end
    if (obs_req_valid !== 1'b1 || obs_req_addr !== tgt) begin
      errors++; $display("FAIL collide_target: got valid %b addr %h want 1 %h", obs_req_valid, obs_req_addr, tgt);
    end
    req_ready_pct = 100;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, '0);
      if (obs_req_fire) begin
        checks++;
        if (obs_req_addr !== want_req_addr) begin errors++; $display("FAIL collide_req_addr: got %h want %h", obs_req_addr, want_req_addr); end
      end
      if (obs_id_fire) begin
        checks++;
        if (obs_id_pc !== want_id_pc || obs_id_instr !== want_id_instr) begin
          errors++; $display("FAIL collide_id: got pc %h instr %h want pc %h instr %h", obs_id_pc, obs_id_instr, want_id_pc, want_id_instr);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic got_id = 1'b0;
    lat_min = 3; lat_max = 3;
    drain();
    req_ready_pct = 100; id_ready_pct = 100;
    step(1'b0, '0, '0);
    checks++;
    if (obs_req_fire !== 1'b1) begin errors++; $display("FAIL midflight_req: got %b want 1", obs_req_fire); end
    @(negedge clk);
    reset = 1'b1; imem_req_ready = 1'b0; id_ready = 1'b0; redirect = 1'b0; imem_resp_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL midflight_reset: got req %b id %b want 0 0", imem_req_valid, id_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_req_addr = RESET_PC;
    exp_id_pc    = RESET_PC;
    if (due_q.size() > 0) due_q[0] = cyc;
    req_ready_pct = 0;
    repeat (3) begin
      step(1'b0, '0, '0);
      checks++;
      if (obs_id_valid !== 1'b0) begin errors++; $display("FAIL stale_ignored: got id_valid %b want 0", obs_id_valid); end
    end
    req_ready_pct = 100; lat_min = 1; lat_max = 2;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, '0);
      if (obs_req_fire) begin
        checks++;
        if (obs_req_addr !== want_req_addr) begin errors++; $display("FAIL refetch_req_addr: got %h want %h", obs_req_addr, want_req_addr); end
      end
      if (obs_id_fire) begin
        checks++;
        if (!got_id && obs_id_pc !== RESET_PC) begin errors++; $display("FAIL refetch_first_pc: got %h want %h", obs_id_pc, RESET_PC); end
        else if (obs_id_pc !== want_id_pc || obs_id_instr !== want_id_instr) begin
          errors++; $display("FAIL refetch_id: got pc %h instr %h want pc %h instr %h", obs_id_pc, obs_id_instr, want_id_pc, want_id_instr);
        end
        got_id = 1'b1;
      end
    end
    checks++;
    if (!got_id) begin errors++; $display("FAIL refetch_none: got 0 want >=1"); end
  endtask

  task automatic test_random_redirects();
    logic rdr;
    logic [31:0] rpc, rimm;
    int n_id = 0;
    req_ready_pct = 70; id_ready_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      rdr  = (i == 100) || ($urandom_range(99) < 4);
      rpc  = (i == 100) ? 32'hFFFF_FFF0 : ($urandom & ~32'h3);
      rimm = (i == 100) ? 32'h0000_0014 : {{20{1'b0}}, 12'($urandom)};
      step(rdr, rpc, rimm);
      if (rdr) begin
        checks++;
        if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL rand_suppress: got %b want 0", obs_req_valid); end
      end
      if (obs_req_fire) begin
        checks++;
        if (obs_req_addr !== want_req_addr) begin errors++; $display("FAIL rand_req_addr: got %h want %h", obs_req_addr, want_req_addr); end
      end
      if (obs_id_fire) begin
        checks++; n_id++;
        if (obs_id_pc !== want_id_pc || obs_id_instr !== want_id_instr) begin
          errors++; $display("FAIL rand_id: got pc %h instr %h want pc %h instr %h", obs_id_pc, obs_id_instr, want_id_pc, want_id_instr);
        end
      end
    end
    checks++;
    if (n_id < 50) begin errors++; $display("FAIL rand_progress: got %0d want >=50", n_id); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_reset_midflight();
    test_random_redirects();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
